// File: rtl/project_mux_pkg.sv
// Shared definitions for the project IO multiplexer: FSM state encoding,
// Wishbone register offsets and the SEL/STATUS bit-field layout.
package project_mux_pkg;

  localparam int unsigned IDX_W = 5;   // project index field width
  localparam int unsigned CNT_W = 16;  // saturating switch counter width

  // Register offsets relative to BASE_ADDR
  localparam logic [31:0] SEL_OFFSET    = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFFSET = 32'h0000_0004;

  // SEL layout
  localparam int unsigned SEL_IDX_LSB = 0;
  localparam int unsigned SEL_EN_BIT  = 7;

  // STATUS layout
  localparam int unsigned ST_IDX_LSB   = 0;
  localparam int unsigned ST_STATE_LSB = 5;
  localparam int unsigned ST_ERR_BIT   = 7;
  localparam int unsigned ST_PEND_BIT  = 8;
  localparam int unsigned ST_CNT_LSB   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ARM   = 2'd3
  } mux_state_e;

  // Accepted selection as held in the SEL register
  typedef struct packed {
    logic             en;
    logic [IDX_W-1:0] idx;
  } sel_t;

  // Assemble the STATUS word from its fields
  function automatic logic [31:0] pack_status(
    input logic [IDX_W-1:0] cur,
    input logic [1:0]       st,
    input logic             err,
    input logic             pend,
    input logic [CNT_W-1:0] cnt
  );
    logic [31:0] s;
    s = 32'h0;
    s[ST_IDX_LSB +: IDX_W]   = cur;
    s[ST_STATE_LSB +: 2]     = st;
    s[ST_ERR_BIT]            = err;
    s[ST_PEND_BIT]           = pend;
    s[ST_CNT_LSB +: CNT_W]   = cnt;
    return s;
  endfunction

endpackage

// File: rtl/project_mux_wb_regs.sv
// Wishbone slave for the project mux: address decode, single-cycle ack,
// SEL register, sticky error flag and STATUS readback.
// Ports:
//   wb_clk_i/wb_rst_i  clock, synchronous active-high reset
//   wbs_*              Wishbone slave interface
//   cur_idx_i, state_i, pending_i, switches_i  live status from the FSM
//   sel_wr_c, sel_en_c, sel_idx_c              accepted SEL write (combinational pulse)
module project_mux_wb_regs
  import project_mux_pkg::*;
#(
  parameter int unsigned NUM_PROJECTS = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_dat_i,
  input  logic [31:0]      wbs_adr_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  input  logic [IDX_W-1:0] cur_idx_i,
  input  logic [1:0]       state_i,
  input  logic             pending_i,
  input  logic [CNT_W-1:0] switches_i,
  output logic             sel_wr_c,
  output logic             sel_en_c,
  output logic [IDX_W-1:0] sel_idx_c
);

  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  sel_t        sel_q, sel_d;
  logic        err_q, err_d;

  logic hit_c, is_sel_c, is_status_c, wr_sel_c, bad_idx_c;
  logic unused_bits;

  assign unused_bits = ^{wbs_sel_i[3:1], wbs_dat_i[31:8], wbs_dat_i[6:5]};

  // Decode; a pending ack blocks the next hit so a held strobe is acked once
  // per two cycles rather than continuously.
  always_comb begin
    is_sel_c    = (wbs_adr_i == BASE_ADDR + SEL_OFFSET);
    is_status_c = (wbs_adr_i == BASE_ADDR + STATUS_OFFSET);
    hit_c       = wbs_stb_i & wbs_cyc_i & ~ack_q & (is_sel_c | is_status_c);
    wr_sel_c    = hit_c & wbs_we_i & is_sel_c & wbs_sel_i[0];
    sel_idx_c   = wbs_dat_i[SEL_IDX_LSB +: IDX_W];
    sel_en_c    = wbs_dat_i[SEL_EN_BIT];
    bad_idx_c   = sel_en_c & ({{(32-IDX_W){1'b0}}, sel_idx_c} >= 32'(NUM_PROJECTS));
    sel_wr_c    = wr_sel_c & ~bad_idx_c;
  end

  // Register next-state: SEL holds last accepted value, err is sticky
  always_comb begin
    ack_d = hit_c;
    dat_d = 32'h0;
    sel_d = sel_q;
    err_d = err_q;
    if (sel_wr_c) begin
      sel_d.en  = sel_en_c;
      sel_d.idx = sel_idx_c;
      err_d     = 1'b0;
    end else if (wr_sel_c) begin
      err_d = 1'b1;
    end
    if (hit_c && !wbs_we_i) begin
      if (is_status_c)
        dat_d = pack_status(cur_idx_i, state_i, err_q, pending_i, switches_i);
      else
        dat_d = {24'h0, sel_q.en, 2'b00, sel_q.idx};
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= 32'h0;
      sel_q <= '0;
      err_q <= 1'b0;
    end else begin
      ack_q <= ack_d;
      dat_q <= dat_d;
      sel_q <= sel_d;
      err_q <= err_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

endmodule

// File: rtl/project_mux.sv
// Project IO multiplexer: owns the user IO, one-hot enables the selected
// project and registers its io_out/io_oeb onto the pads. Switching passes
// through a guard window with all pads tristated, then one arm cycle where
// the new project is active but not yet driving the pads.
// Ports:
//   wb_clk_i/wb_rst_i    clock, synchronous active-high reset
//   wbs_*                Wishbone slave (SEL at BASE+0, STATUS at BASE+4)
//   proj_io_out/oeb      packed per-project IO, project p at [p*IO_W +: IO_W]
//   active               one-hot (or zero) project enable
//   io_out/io_oeb        pad outputs (oeb 1 = input)
module project_mux
  import project_mux_pkg::*;
#(
  parameter int unsigned NUM_PROJECTS = 8,
  parameter int unsigned IO_W         = 38,
  parameter int unsigned GUARD_CYCLES = 4,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic                         wbs_stb_i,
  input  logic                         wbs_cyc_i,
  input  logic                         wbs_we_i,
  input  logic [3:0]                   wbs_sel_i,
  input  logic [31:0]                  wbs_dat_i,
  input  logic [31:0]                  wbs_adr_i,
  output logic                         wbs_ack_o,
  output logic [31:0]                  wbs_dat_o,
  input  logic [NUM_PROJECTS*IO_W-1:0] proj_io_out,
  input  logic [NUM_PROJECTS*IO_W-1:0] proj_io_oeb,
  output logic [NUM_PROJECTS-1:0]      active,
  output logic [IO_W-1:0]              io_out,
  output logic [IO_W-1:0]              io_oeb
);

  localparam int unsigned GUARD_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(GUARD_CYCLES - 1);

  mux_state_e             state_q, state_d;
  logic [IDX_W-1:0]       cur_q, cur_d;
  logic [IDX_W-1:0]       next_idx_q, next_idx_d;
  logic                   next_en_q, next_en_d;
  logic                   pending_q, pending_d;
  logic [GUARD_W-1:0]     guard_q, guard_d;
  logic [CNT_W-1:0]       switches_q, switches_d;
  logic [NUM_PROJECTS-1:0] active_q, active_d;
  logic [IO_W-1:0]        io_out_q, io_out_d;
  logic [IO_W-1:0]        io_oeb_q, io_oeb_d;

  logic                   sel_wr_c;
  logic                   sel_en_c;
  logic [IDX_W-1:0]       sel_idx_c;

  project_mux_wb_regs #(
    .NUM_PROJECTS (NUM_PROJECTS),
    .BASE_ADDR    (BASE_ADDR)
  ) u_regs (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .wbs_stb_i  (wbs_stb_i),
    .wbs_cyc_i  (wbs_cyc_i),
    .wbs_we_i   (wbs_we_i),
    .wbs_sel_i  (wbs_sel_i),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_adr_i  (wbs_adr_i),
    .wbs_ack_o  (wbs_ack_o),
    .wbs_dat_o  (wbs_dat_o),
    .cur_idx_i  (cur_q),
    .state_i    (state_q),
    .pending_i  (pending_q),
    .switches_i (switches_q),
    .sel_wr_c   (sel_wr_c),
    .sel_en_c   (sel_en_c),
    .sel_idx_c  (sel_idx_c)
  );

  // Next-state logic for the switch sequencer
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    next_idx_d = next_idx_q;
    next_en_d  = next_en_q;
    pending_d  = pending_q;
    guard_d    = guard_q;
    switches_d = switches_q;

    case (state_q)
      ST_IDLE: begin
        // A disable write while idle has nothing to tear down
        if (sel_wr_c && sel_en_c) begin
          state_d    = ST_DRAIN;
          next_idx_d = sel_idx_c;
          next_en_d  = 1'b1;
          guard_d    = GUARD_LOAD;
        end
      end
      ST_RUN: begin
        if (sel_wr_c) begin
          state_d    = ST_DRAIN;
          next_idx_d = sel_idx_c;
          next_en_d  = sel_en_c;
          guard_d    = GUARD_LOAD;
        end
      end
      ST_DRAIN: begin
        if (sel_wr_c) begin
          next_idx_d = sel_idx_c;
          next_en_d  = sel_en_c;
          pending_d  = 1'b1;
        end
        if (guard_q == '0) begin
          // A write landing on the expiry cycle restarts the guard window
          if (sel_wr_c) begin
            guard_d = GUARD_LOAD;
          end else begin
            pending_d = 1'b0;
            if (next_en_q) begin
              state_d = ST_ARM;
              cur_d   = next_idx_q;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end else begin
          guard_d = guard_q - GUARD_W'(1);
        end
      end
      ST_ARM: begin
        if (sel_wr_c) begin
          state_d    = ST_DRAIN;
          next_idx_d = sel_idx_c;
          next_en_d  = sel_en_c;
          guard_d    = GUARD_LOAD;
        end else begin
          state_d = ST_RUN;
          if (switches_q != {CNT_W{1'b1}})
            switches_d = switches_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs follow the next state so active and the pads change together
  always_comb begin
    active_d = '0;
    io_out_d = '0;
    io_oeb_d = '1;
    if (state_d == ST_RUN || state_d == ST_ARM)
      active_d = NUM_PROJECTS'(1) << cur_d;
    // RUN is only entered from ARM or RUN, so cur is already stable here
    if (state_d == ST_RUN) begin
      io_out_d = proj_io_out[32'(cur_q) * IO_W +: IO_W];
      io_oeb_d = proj_io_oeb[32'(cur_q) * IO_W +: IO_W];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      cur_q      <= '0;
      next_idx_q <= '0;
      next_en_q  <= 1'b0;
      pending_q  <= 1'b0;
      guard_q    <= '0;
      switches_q <= '0;
      active_q   <= '0;
      io_out_q   <= '0;
      io_oeb_q   <= '1;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      next_idx_q <= next_idx_d;
      next_en_q  <= next_en_d;
      pending_q  <= pending_d;
      guard_q    <= guard_d;
      switches_q <= switches_d;
      active_q   <= active_d;
      io_out_q   <= io_out_d;
      io_oeb_q   <= io_oeb_d;
    end
  end

  assign active = active_q;
  assign io_out = io_out_q;
  assign io_oeb = io_oeb_q;

endmodule

// File: tb/tb_project_mux.sv
// Directed bench for project_mux: hand sequences for switch timing and
// corner cases plus a table of SEL writes with expected settled status.
module tb_project_mux;

  localparam int unsigned NP   = 8;
  localparam int unsigned IOW  = 38;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] SEL  = BASE;
  localparam logic [31:0] STAT = BASE + 32'h4;
  localparam logic [IOW-1:0] ONES = {IOW{1'b1}};

  logic              clk;
  logic              rst;
  logic              stb, cyc, we;
  logic [3:0]        bsel;
  logic [31:0]       dat_i, adr;
  logic              ack;
  logic [31:0]       dat_o;
  logic [NP*IOW-1:0] proj_out, proj_oeb;
  logic [NP-1:0]     active;
  logic [IOW-1:0]    io_out, io_oeb;

  logic [IOW-1:0] p_out [NP];
  logic [IOW-1:0] p_oeb [NP];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  project_mux #(
    .NUM_PROJECTS (NP),
    .IO_W         (IOW),
    .GUARD_CYCLES (4),
    .BASE_ADDR    (BASE)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbs_stb_i   (stb),
    .wbs_cyc_i   (cyc),
    .wbs_we_i    (we),
    .wbs_sel_i   (bsel),
    .wbs_dat_i   (dat_i),
    .wbs_adr_i   (adr),
    .wbs_ack_o   (ack),
    .wbs_dat_o   (dat_o),
    .proj_io_out (proj_out),
    .proj_io_oeb (proj_oeb),
    .active      (active),
    .io_out      (io_out),
    .io_oeb      (io_oeb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      proj_out[p*IOW +: IOW] = p_out[p];
      proj_oeb[p*IOW +: IOW] = p_oeb[p];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Safety invariants on every cycle: never multi-hot, idle pads stay tristated
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if ($countones(active) > 1 || (active == '0 && (io_oeb !== ONES || io_out !== '0))) begin
        errors++;
        $display("FAIL invariant: active %b io_oeb %h io_out %h", active, io_oeb, io_out);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = a; dat_i = d; bsel = s;
    tick();
    check("write_ack", 64'(ack), 64'd1);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    tick();
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = a; bsel = 4'hF;
    tick();
    check("read_ack", 64'(ack), 64'd1);
    d = dat_o;
    stb = 1'b0; cyc = 1'b0;
    tick();
  endtask

  typedef struct {
    logic [7:0]  wdata;
    logic [3:0]  wsel;
    logic [31:0] exp_status;
    logic [31:0] exp_sel;
    logic [7:0]  exp_active;
    int          exp_proj;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [31:0] rd;
    logic [IOW-1:0] old_v;

    // Entry state: RUN on project 6, count 2, err 0, SEL 0x86
    vecs[0] = '{8'h89, 4'hF, 32'h0002_00A6, 32'h86, 8'h40,  6};
    vecs[1] = '{8'h81, 4'hF, 32'h0003_0021, 32'h81, 8'h02,  1};
    vecs[2] = '{8'h87, 4'hF, 32'h0004_0027, 32'h87, 8'h80,  7};
    vecs[3] = '{8'h88, 4'hF, 32'h0004_00A7, 32'h87, 8'h80,  7};
    vecs[4] = '{8'h80, 4'hF, 32'h0005_0020, 32'h80, 8'h01,  0};
    vecs[5] = '{8'h00, 4'hF, 32'h0005_0000, 32'h00, 8'h00, -1};
    vecs[6] = '{8'h05, 4'hF, 32'h0005_0000, 32'h05, 8'h00, -1};
    vecs[7] = '{8'h9F, 4'hF, 32'h0005_0080, 32'h05, 8'h00, -1};
    vecs[8] = '{8'h83, 4'hF, 32'h0006_0023, 32'h83, 8'h08,  3};
    vecs[9] = '{8'h81, 4'hE, 32'h0006_0023, 32'h83, 8'h08,  3};

    for (int p = 0; p < NP; p++) begin
      p_out[p] = {6'(p), 32'hA5A5_0000 | 32'(p)};
      p_oeb[p] = {6'h2A, 32'(p) << 4};
    end

    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; bsel = 4'h0; dat_i = 32'h0; adr = 32'h0;
    tick(); tick();
    rst = 1'b0;
    mon_en = 1'b1;

    // Reset state
    check("rst_active", 64'(active), 64'h0);
    check("rst_io_oeb", 64'(io_oeb), 64'(ONES));
    check("rst_io_out", 64'(io_out), 64'h0);
    check("rst_ack", 64'(ack), 64'h0);
    check("rst_dat", 64'(dat_o), 64'h0);
    wb_read(STAT, rd);
    check("rst_status", 64'(rd), 64'h0);

    // Switch IDLE -> project 2, cycle by cycle
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = SEL; dat_i = 32'h82; bsel = 4'hF;
    tick();
    check("sw2_ack", 64'(ack), 64'd1);
    check("sw2_drain_act0", 64'(active), 64'h0);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    tick();
    check("sw2_ack_drop", 64'(ack), 64'd0);
    check("sw2_drain_act1", 64'(active), 64'h0);
    tick();
    check("sw2_drain_act2", 64'(active), 64'h0);
    tick();
    check("sw2_drain_act3", 64'(active), 64'h0);
    tick();
    check("sw2_arm_active", 64'(active), 64'h04);
    check("sw2_arm_oeb", 64'(io_oeb), 64'(ONES));
    tick();
    check("sw2_run_active", 64'(active), 64'h04);
    check("sw2_run_out", 64'(io_out), 64'(p_out[2]));
    check("sw2_run_oeb", 64'(io_oeb), 64'(p_oeb[2]));
    old_v = p_out[2];
    p_out[2] = 38'h2A_1234_5678;
    #2;
    check("sw2_lag_old", 64'(io_out), 64'(old_v));
    tick();
    check("sw2_lag_new", 64'(io_out), 64'(38'h2A_1234_5678));
    wb_read(STAT, rd);
    check("sw2_status", 64'(rd), 64'h0001_0022);

    // Two writes inside one guard window: last one wins, pending visible
    wb_write(SEL, 32'h85, 4'hF);
    wb_write(SEL, 32'h86, 4'hF);
    wb_read(STAT, rd);
    check("dbl_pending_status", 64'(rd), 64'h0001_0142);
    check("dbl_active", 64'(active), 64'h40);
    wb_read(STAT, rd);
    check("dbl_final_status", 64'(rd), 64'h0002_0026);
    wb_read(SEL, rd);
    check("dbl_sel", 64'(rd), 64'h86);

    // Table of SEL writes with settled expectations
    for (int i = 0; i < 10; i++) begin
      wb_write(SEL, {24'h0, vecs[i].wdata}, vecs[i].wsel);
      for (int k = 0; k < 6; k++) tick();
      wb_read(STAT, rd);
      check($sformatf("vec%0d_status", i), 64'(rd), 64'(vecs[i].exp_status));
      check($sformatf("vec%0d_active", i), 64'(active), 64'(vecs[i].exp_active));
      if (vecs[i].exp_proj >= 0) begin
        check($sformatf("vec%0d_io_out", i), 64'(io_out), 64'(p_out[vecs[i].exp_proj]));
        check($sformatf("vec%0d_io_oeb", i), 64'(io_oeb), 64'(p_oeb[vecs[i].exp_proj]));
      end else begin
        check($sformatf("vec%0d_io_oeb", i), 64'(io_oeb), 64'(ONES));
      end
      wb_read(SEL, rd);
      check($sformatf("vec%0d_sel", i), 64'(rd), 64'(vecs[i].exp_sel));
    end

    // Disable from RUN on project 3: DRAIN visible, then IDLE
    wb_write(SEL, 32'h00, 4'hF);
    check("dis_active", 64'(active), 64'h0);
    wb_read(STAT, rd);
    check("dis_drain_status", 64'(rd), 64'h0006_0043);
    tick();
    wb_read(STAT, rd);
    check("dis_idle_status", 64'(rd), 64'h0006_0003);
    check("dis_oeb", 64'(io_oeb), 64'(ONES));

    // Held strobe on STATUS: acks alternate, never back-to-back
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = STAT;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("hold_ack%0d", i), 64'(ack), (i % 2 == 0) ? 64'd1 : 64'd0);
      if (i % 2 == 0) check($sformatf("hold_dat%0d", i), 64'(dat_o), 64'h0006_0003);
    end
    stb = 1'b0; cyc = 1'b0;
    tick();
    check("hold_ack_end", 64'(ack), 64'd0);

    // Unmapped address: no ack, no effect even with a write
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE + 32'h8; dat_i = 32'h81; bsel = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("miss_ack%0d", i), 64'(ack), 64'd0);
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    wb_read(STAT, rd);
    check("miss_status", 64'(rd), 64'h0006_0003);

    // Reset while project 3 is driving the pads
    wb_write(SEL, 32'h83, 4'hF);
    for (int k = 0; k < 6; k++) tick();
    p_out[3] = 38'h15;
    p_oeb[3] = '0;
    tick();
    check("mid_run_out", 64'(io_out), 64'h15);
    check("mid_run_oeb", 64'(io_oeb), 64'h0);
    wb_read(STAT, rd);
    check("mid_run_status", 64'(rd), 64'h0007_0023);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rrst_active", 64'(active), 64'h0);
    check("rrst_io_out", 64'(io_out), 64'h0);
    check("rrst_io_oeb", 64'(io_oeb), 64'(ONES));
    wb_read(STAT, rd);
    check("rrst_status", 64'(rd), 64'h0);
    wb_read(SEL, rd);
    check("rrst_sel", 64'(rd), 64'h0);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
